// File: rtl/obi_2_axi_mo.sv
// obi_2_axi_mo: single-clock OBI-to-AXI4 bridge with in-order responses.
// Each OBI request becomes a single-beat AXI transaction. Reads and writes are
// never mixed in flight, so same-ID ordering is enough to return responses in
// request order.

package obi_2_axi_mo_pkg;
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
    } axi_ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } axi_w_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } axi_b_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        axi_b_t b;
        logic   r_valid;
        axi_r_t r;
    } axi_resp_t;
endpackage

module obi_2_axi_mo #(
    parameter int unsigned ADDRW           = 32,
    parameter int unsigned DATAW           = 32,
    parameter int unsigned STRBW           = DATAW / 8,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter logic [3:0]  AXI_ID          = 4'd0,
    parameter type         axi_req_t       = obi_2_axi_mo_pkg::axi_req_t,
    parameter type         axi_resp_t      = obi_2_axi_mo_pkg::axi_resp_t
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    output logic             gnt_o,
    input  logic [ADDRW-1:0] addr_i,
    input  logic             we_i,
    input  logic [STRBW-1:0] be_i,
    input  logic [DATAW-1:0] wdata_i,
    output logic             rvalid_o,
    output logic [DATAW-1:0] rdata_o,
    output logic             err_o,
    output logic             spurious_o,
    output axi_req_t         axi_req_o,
    input  axi_resp_t        axi_resp_i
);
    localparam int unsigned     CNTW    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(MAX_OUTSTANDING);

    logic [CNTW-1:0]  cnt;
    logic             cur_we;
    logic             pend_valid, pend_we;
    logic [ADDRW-1:0] pend_addr;
    logic [STRBW-1:0] pend_be;
    logic [DATAW-1:0] pend_wdata;
    logic             aw_done, w_done, ar_done;
    logic             rvalid_q, err_q, spurious_q;
    logic [DATAW-1:0] rdata_q;

    logic aw_valid, w_valid, ar_valid;
    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic exp_b, exp_r, resp_now, spurious_now;
    logic pend_done_now, type_ok, accept;
    logic unused_resp;

    assign aw_valid = pend_valid & pend_we & ~aw_done;
    assign w_valid  = pend_valid & pend_we & ~w_done;
    assign ar_valid = pend_valid & ~pend_we & ~ar_done;

    assign aw_hs = aw_valid & axi_resp_i.aw_ready;
    assign w_hs  = w_valid & axi_resp_i.w_ready;
    assign ar_hs = ar_valid & axi_resp_i.ar_ready;
    assign b_hs  = ~rst_i & axi_resp_i.b_valid;
    assign r_hs  = ~rst_i & axi_resp_i.r_valid;

    assign exp_b        = b_hs & (cnt != '0) & cur_we;
    assign exp_r        = r_hs & (cnt != '0) & ~cur_we;
    assign resp_now     = exp_b | exp_r;
    assign spurious_now = (b_hs & ~exp_b) | (r_hs & ~exp_r);

    assign pend_done_now = pend_valid & (pend_we ? ((aw_done | aw_hs) & (w_done | w_hs))
                                                 : (ar_done | ar_hs));

    // A type switch is allowed in the very cycle the last old-type response lands.
    assign type_ok = (cnt == '0) | (we_i == cur_we) | ((cnt == CNTW'(1)) & resp_now);
    assign gnt_o   = ~rst_i & req_i & ((cnt < CNT_MAX) | resp_now)
                   & (~pend_valid | pend_done_now) & type_ok;
    assign accept  = gnt_o;

    assign unused_resp = ^{axi_resp_i.b.id, axi_resp_i.r.id, axi_resp_i.r.last};

    // Drive AXI request channels from the pending entry.
    always_comb begin
        axi_req_o          = '0;
        axi_req_o.aw.id    = AXI_ID;
        axi_req_o.aw.addr  = pend_addr;
        axi_req_o.aw.len   = 8'd0;
        axi_req_o.aw.size  = 3'($clog2(STRBW));
        axi_req_o.aw.burst = 2'b01;
        axi_req_o.aw_valid = aw_valid;
        axi_req_o.w.data   = pend_wdata;
        axi_req_o.w.strb   = pend_be;
        axi_req_o.w.last   = 1'b1;
        axi_req_o.w_valid  = w_valid;
        axi_req_o.ar.id    = AXI_ID;
        axi_req_o.ar.addr  = pend_addr;
        axi_req_o.ar.len   = 8'd0;
        axi_req_o.ar.size  = 3'($clog2(STRBW));
        axi_req_o.ar.burst = 2'b01;
        axi_req_o.ar_valid = ar_valid;
        axi_req_o.b_ready  = ~rst_i;
        axi_req_o.r_ready  = ~rst_i;
    end

    // Pending entry: load on accept, track per-channel handshakes, clear when all done.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_valid <= 1'b0;
            pend_we    <= 1'b0;
            pend_addr  <= '0;
            pend_be    <= '0;
            pend_wdata <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            ar_done    <= 1'b0;
        end else if (accept) begin
            pend_valid <= 1'b1;
            pend_we    <= we_i;
            pend_addr  <= addr_i;
            pend_be    <= be_i;
            pend_wdata <= wdata_i;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            ar_done    <= 1'b0;
        end else if (pend_done_now) begin
            pend_valid <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            ar_done    <= 1'b0;
        end else begin
            aw_done <= aw_done | aw_hs;
            w_done  <= w_done | w_hs;
            ar_done <= ar_done | ar_hs;
        end
    end

    // Outstanding count and the type of the transactions in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt    <= '0;
            cur_we <= 1'b0;
        end else begin
            if (accept && !resp_now) begin
                cnt <= cnt + CNTW'(1);
            end else if (!accept && resp_now) begin
                cnt <= cnt - CNTW'(1);
            end
            if (accept) begin
                cur_we <= we_i;
            end
        end
    end

    // Registered OBI response and spurious-response pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            spurious_q <= 1'b0;
        end else begin
            rvalid_q   <= resp_now;
            spurious_q <= spurious_now;
            err_q      <= resp_now & (exp_b ? axi_resp_i.b.resp[1] : axi_resp_i.r.resp[1]);
            if (resp_now) begin
                rdata_q <= exp_b ? '0 : axi_resp_i.r.data;
            end
        end
    end

    assign rvalid_o   = rvalid_q;
    assign err_o      = err_q;
    assign rdata_o    = rdata_q;
    assign spurious_o = spurious_q;

endmodule

// File: tb/tb_obi_2_axi_mo.sv
// Directed testbench for obi_2_axi_mo with default parameters.
module tb_obi_2_axi_mo;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        spurious_o;
    obi_2_axi_mo_pkg::axi_req_t  axi_req;
    obi_2_axi_mo_pkg::axi_resp_t axi_resp;

    int checks = 0;
    int errors = 0;

    obi_2_axi_mo dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .gnt_o      (gnt_o),
        .addr_i     (addr_i),
        .we_i       (we_i),
        .be_i       (be_i),
        .wdata_i    (wdata_i),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .spurious_o (spurious_o),
        .axi_req_o  (axi_req),
        .axi_resp_i (axi_resp)
    );

    always #5 clk_i = ~clk_i;

    // Advance to just after the next rising edge; inputs are then driven and
    // outputs checked one more time unit later, well before the next edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_i = 1'b1; we_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); settle();
            checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL reset_gnt cyc%0d got %b exp 0", i, gnt_o); end
            checks++; if ({axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid} !== 3'b000) begin
                errors++; $display("FAIL reset_valids cyc%0d got %b exp 000", i, {axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid}); end
            checks++; if ({rvalid_o, err_o, spurious_o, axi_req.b_ready, axi_req.r_ready} !== 5'b0) begin
                errors++; $display("FAIL reset_outs cyc%0d got %b exp 00000", i, {rvalid_o, err_o, spurious_o, axi_req.b_ready, axi_req.r_ready}); end
            checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata_o); end
        end
        step();
        rst_i = 1'b0; req_i = 1'b0;
    endtask

    task automatic test_single_read();
        step();
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'hAB; axi_resp.ar_ready = 1'b1; settle();
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL rd_gnt got %b exp 1", gnt_o); end
        step();
        req_i = 1'b0; settle();
        checks++; if (axi_req.ar_valid !== 1'b1) begin errors++; $display("FAIL rd_ar_valid got %b exp 1", axi_req.ar_valid); end
        checks++; if (axi_req.ar.addr !== 32'hAB) begin errors++; $display("FAIL rd_ar_addr got %h exp ab", axi_req.ar.addr); end
        checks++; if (axi_req.ar.len !== 8'd0 || axi_req.ar.size !== 3'd2 || axi_req.ar.burst !== 2'b01) begin
            errors++; $display("FAIL rd_ar_fields got len %0d size %0d burst %0d exp 0 2 1", axi_req.ar.len, axi_req.ar.size, axi_req.ar.burst); end
        step(); settle();
        checks++; if (axi_req.ar_valid !== 1'b0) begin errors++; $display("FAIL rd_ar_drop got %b exp 0", axi_req.ar_valid); end
        step();
        axi_resp.r_valid = 1'b1; axi_resp.r.data = 32'h1234_5678; axi_resp.r.resp = 2'b00; settle();
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL rd_rvalid_early got %b exp 0", rvalid_o); end
        step();
        axi_resp.r_valid = 1'b0; settle();
        checks++; if (rvalid_o !== 1'b1 || rdata_o !== 32'h1234_5678 || err_o !== 1'b0) begin
            errors++; $display("FAIL rd_resp got v%b d%h e%b exp v1 d12345678 e0", rvalid_o, rdata_o, err_o); end
        step(); settle();
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL rd_rvalid_pulse got %b exp 0", rvalid_o); end
    endtask

    task automatic test_split_write();
        step();
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h40; wdata_i = 32'hDEAD_BEEF; be_i = 4'h3;
        axi_resp.aw_ready = 1'b0; axi_resp.w_ready = 1'b0; settle();
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL wr_gnt got %b exp 1", gnt_o); end
        step();
        addr_i = 32'h44; wdata_i = 32'h0000_0011; be_i = 4'hF; settle();
        checks++; if (axi_req.aw_valid !== 1'b1 || axi_req.w_valid !== 1'b1) begin
            errors++; $display("FAIL wr_valids got aw%b w%b exp 11", axi_req.aw_valid, axi_req.w_valid); end
        checks++; if (axi_req.w.strb !== 4'h3 || axi_req.w.last !== 1'b1 || axi_req.w.data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL wr_wfields got strb %h last %b data %h exp 3 1 deadbeef", axi_req.w.strb, axi_req.w.last, axi_req.w.data); end
        checks++; if (axi_req.aw.addr !== 32'h40) begin errors++; $display("FAIL wr_aw_addr got %h exp 40", axi_req.aw.addr); end
        checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL wr_block0 got %b exp 0", gnt_o); end
        step();
        axi_resp.w_ready = 1'b1; settle();
        checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL wr_block1 got %b exp 0", gnt_o); end
        step();
        axi_resp.w_ready = 1'b0; settle();
        checks++; if (axi_req.w_valid !== 1'b0 || axi_req.aw_valid !== 1'b1 || gnt_o !== 1'b0) begin
            errors++; $display("FAIL wr_after_w got w%b aw%b g%b exp 0 1 0", axi_req.w_valid, axi_req.aw_valid, gnt_o); end
        step();
        axi_resp.aw_ready = 1'b1; settle();
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL wr_gnt_on_aw got %b exp 1", gnt_o); end
        step();
        req_i = 1'b0; axi_resp.w_ready = 1'b1; settle();
        checks++; if (axi_req.aw.addr !== 32'h44 || axi_req.aw_valid !== 1'b1) begin
            errors++; $display("FAIL wr2_aw got addr %h v%b exp 44 1", axi_req.aw.addr, axi_req.aw_valid); end
        step();
        axi_resp.b_valid = 1'b1; axi_resp.b.resp = 2'b10; settle();
        step();
        axi_resp.b.resp = 2'b00; settle();
        checks++; if (rvalid_o !== 1'b1 || err_o !== 1'b1 || rdata_o !== 32'h0) begin
            errors++; $display("FAIL wr_slverr got v%b e%b d%h exp v1 e1 d0", rvalid_o, err_o, rdata_o); end
        step();
        axi_resp.b_valid = 1'b0; settle();
        checks++; if (rvalid_o !== 1'b1 || err_o !== 1'b0) begin
            errors++; $display("FAIL wr2_okay got v%b e%b exp v1 e0", rvalid_o, err_o); end
        step(); settle();
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL wr_rvalid_pulse got %b exp 0", rvalid_o); end
        axi_resp.aw_ready = 1'b0; axi_resp.w_ready = 1'b0;
    endtask

    task automatic test_outstanding();
        logic        exp_gnt [13] = '{1,1,1,1,0,0,1,1,0,0,0,0,0};
        logic [31:0] want;
        int          ngnt  = 0;
        int          early = 0;
        axi_resp.ar_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step();
            req_i  = (i < 8);
            we_i   = 1'b0;
            addr_i = 32'h100 + 32'(4 * ngnt);
            axi_resp.r_valid = (i >= 6 && i <= 11);
            axi_resp.r.data  = 32'(i - 5);
            axi_resp.r.resp  = 2'b00;
            settle();
            checks++; if (gnt_o !== exp_gnt[i]) begin errors++; $display("FAIL lim_gnt cyc%0d got %b exp %b", i, gnt_o, exp_gnt[i]); end
            if (gnt_o === 1'b1) ngnt++;
            if (i == 5) early = ngnt;
            if (i >= 7) begin
                want = 32'(i - 6);
                checks++; if (rvalid_o !== 1'b1 || rdata_o !== want) begin
                    errors++; $display("FAIL lim_rdata cyc%0d got v%b d%h exp v1 d%h", i, rvalid_o, rdata_o, want); end
            end
        end
        checks++; if (early != 4) begin errors++; $display("FAIL lim_count got %0d exp 4", early); end
        step();
        axi_resp.r_valid = 1'b0; settle();
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL lim_drain got %b exp 0", rvalid_o); end
    endtask

    task automatic test_type_switch();
        logic exp_gnt [6] = '{1,1,0,0,0,1};
        axi_resp.aw_ready = 1'b1; axi_resp.w_ready = 1'b1; axi_resp.ar_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            req_i   = 1'b1;
            we_i    = (i < 2);
            addr_i  = (i < 2) ? 32'h200 + 32'(4 * i) : 32'h300;
            wdata_i = 32'hA0 + 32'(i);
            be_i    = 4'hF;
            axi_resp.b_valid = (i >= 4);
            axi_resp.b.resp  = 2'b00;
            settle();
            checks++; if (gnt_o !== exp_gnt[i]) begin errors++; $display("FAIL sw_gnt cyc%0d got %b exp %b", i, gnt_o, exp_gnt[i]); end
        end
        step();
        req_i = 1'b0; axi_resp.b_valid = 1'b0; axi_resp.ar_ready = 1'b1; settle();
        checks++; if (axi_req.ar_valid !== 1'b1 || axi_req.ar.addr !== 32'h300) begin
            errors++; $display("FAIL sw_ar got v%b addr %h exp v1 300", axi_req.ar_valid, axi_req.ar.addr); end
        checks++; if (rvalid_o !== 1'b1) begin errors++; $display("FAIL sw_b2_resp got %b exp 1", rvalid_o); end
        step();
        axi_resp.r_valid = 1'b1; axi_resp.r.data = 32'h0000_CAFE; axi_resp.r.resp = 2'b11; settle();
        step();
        axi_resp.r_valid = 1'b0; settle();
        checks++; if (rvalid_o !== 1'b1 || rdata_o !== 32'h0000_CAFE || err_o !== 1'b1) begin
            errors++; $display("FAIL sw_rd_resp got v%b d%h e%b exp v1 dcafe e1", rvalid_o, rdata_o, err_o); end
    endtask

    task automatic test_spurious_reset();
        step();
        axi_resp.r_valid = 1'b1; axi_resp.r.data = 32'h55; axi_resp.r.resp = 2'b00; settle();
        step();
        axi_resp.r_valid = 1'b0; settle();
        checks++; if (spurious_o !== 1'b1 || rvalid_o !== 1'b0) begin
            errors++; $display("FAIL spur_idle got s%b v%b exp s1 v0", spurious_o, rvalid_o); end
        step(); settle();
        checks++; if (spurious_o !== 1'b0) begin errors++; $display("FAIL spur_pulse got %b exp 0", spurious_o); end
        axi_resp.ar_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_i = 1'b1; we_i = 1'b0; addr_i = 32'h400 + 32'(4 * i); settle();
            checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL spur_rd_gnt%0d got %b exp 1", i, gnt_o); end
            step();
        end
        req_i = 1'b0;
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h500; wdata_i = 32'h77; be_i = 4'hF;
        axi_resp.aw_ready = 1'b1; axi_resp.w_ready = 1'b1;
        axi_resp.r_valid = 1'b1; axi_resp.r.data = 32'h99; settle();
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL rst_cnt_clear_gnt got %b exp 1", gnt_o); end
        step();
        req_i = 1'b0; settle();
        checks++; if (spurious_o !== 1'b1 || rvalid_o !== 1'b0) begin
            errors++; $display("FAIL rst_spur0 got s%b v%b exp s1 v0", spurious_o, rvalid_o); end
        step();
        axi_resp.r_valid = 1'b0; axi_resp.b_valid = 1'b1; axi_resp.b.resp = 2'b00; settle();
        checks++; if (spurious_o !== 1'b1 || rvalid_o !== 1'b0) begin
            errors++; $display("FAIL rst_spur1 got s%b v%b exp s1 v0", spurious_o, rvalid_o); end
        step();
        axi_resp.b_valid = 1'b0; settle();
        checks++; if (rvalid_o !== 1'b1 || spurious_o !== 1'b0 || rdata_o !== 32'h0) begin
            errors++; $display("FAIL rst_wr_resp got v%b s%b d%h exp v1 s0 d0", rvalid_o, spurious_o, rdata_o); end
    endtask

    initial begin
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = '0; wdata_i = '0;
        axi_resp = '0;
        test_reset();
        test_single_read();
        test_split_write();
        test_outstanding();
        test_type_switch();
        test_spurious_reset();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
